// File: rtl/permutation_sequencer_if.sv
// Shared 320-bit permutation state type and the request/status bundle
// between a permutation client (master) and the sequencer (slave).
package perm_pkg;
  typedef logic [0:4][63:0] type_state;
endpackage

interface permutation_sequencer_if;
  logic                start_i;
  logic                mode_i;
  perm_pkg::type_state state_i;
  perm_pkg::type_state state_o;
  logic                busy_o;
  logic                done_o;
  logic [3:0]          round_o;

  modport master (output start_i, mode_i, state_i,
                  input  state_o, busy_o, done_o, round_o);
  modport slave  (input  start_i, mode_i, state_i,
                  output state_o, busy_o, done_o, round_o);
endinterface

// File: rtl/permutation_sequencer.sv
// Iterative Ascon permutation: one round per clock, p12 (or p6 when
// PERM_P6_MODE_EN is defined and mode_i=1), then a one-cycle done pulse.
module permutation_sequencer (
  input  logic                    clock_i,
  input  logic                    reset_i,
  permutation_sequencer_if.slave  bus
);
  import perm_pkg::*;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_e;

  fsm_e       fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] start_round_s;

  function automatic logic [7:0] round_const(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hF0;
      4'd1:    return 8'hE1;
      4'd2:    return 8'hD2;
      4'd3:    return 8'hC3;
      4'd4:    return 8'hB4;
      4'd5:    return 8'hA5;
      4'd6:    return 8'h96;
      4'd7:    return 8'h87;
      4'd8:    return 8'h78;
      4'd9:    return 8'h69;
      4'd10:   return 8'h5A;
      4'd11:   return 8'h4B;
      default: return 8'h00;
    endcase
  endfunction

  function automatic type_state const_add(input type_state s, input logic [3:0] idx);
    type_state r;
    r = s;
    r[2][7:0] = s[2][7:0] ^ round_const(idx);
    return r;
  endfunction

  // Bitsliced 5-bit S-box applied across all 64 columns at once
  function automatic type_state sub_layer(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0] ^ s[4];
    x1 = s[1];
    x2 = s[2] ^ s[1];
    x3 = s[3];
    x4 = s[4] ^ s[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] r);
    return (x >> r) | (x << (7'd64 - {1'b0, r}));
  endfunction

  function automatic type_state diff_layer(input type_state s);
    type_state r;
    r[0] = s[0] ^ ror64(s[0], 6'd19) ^ ror64(s[0], 6'd28);
    r[1] = s[1] ^ ror64(s[1], 6'd61) ^ ror64(s[1], 6'd39);
    r[2] = s[2] ^ ror64(s[2], 6'd1)  ^ ror64(s[2], 6'd6);
    r[3] = s[3] ^ ror64(s[3], 6'd10) ^ ror64(s[3], 6'd17);
    r[4] = s[4] ^ ror64(s[4], 6'd7)  ^ ror64(s[4], 6'd41);
    return r;
  endfunction

`ifdef PERM_P6_MODE_EN
  assign start_round_s = bus.mode_i ? 4'd6 : 4'd0;
`else
  logic mode_unused_s;
  assign mode_unused_s = bus.mode_i;
  assign start_round_s = 4'd0;
`endif

  // Next-state: accept requests only from IDLE/DONE, one round per RUN cycle
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          fsm_d   = RUN;
          state_d = bus.state_i;
          round_d = start_round_s;
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        state_d = diff_layer(sub_layer(const_add(state_q, round_q)));
        if (round_q == 4'd11) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
    busy_d = (fsm_d == RUN);
    done_d = (fsm_d == DONE);
  end

  // State, round index and status flags; reset wins over everything
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.state_o = state_q;
  assign bus.round_o = round_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
endmodule

// File: tb/tb_permutation_sequencer.sv
// Random + directed bench: a trace-based Ascon reference (S-box table lookup
// per bit column) predicts busy/done/round/state every cycle.
module tb_permutation_sequencer;
  import perm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  permutation_sequencer_if bus ();

  permutation_sequencer dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] round;
    type_state  st;
  } exp_t;

  exp_t cur;
  exp_t trace[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [4:0] sbox_tab [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  int rot_a [0:4] = '{19, 61, 1, 10, 7};
  int rot_b [0:4] = '{28, 39, 6, 17, 41};

  task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] rot_r(input logic [63:0] x, input int r);
    logic [127:0] d;
    d = {x, x} >> r;
    return d[63:0];
  endfunction

  function automatic type_state ref_round(input type_state s, input int idx);
    logic [63:0] w [0:4];
    logic [63:0] t;
    logic [4:0]  v, o;
    type_state   r;
    for (int i = 0; i < 5; i++) w[i] = s[i];
    w[2][7:0] = w[2][7:0] ^ 8'(((15 - idx) << 4) | idx);
    for (int b = 0; b < 64; b++) begin
      v = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
      o = sbox_tab[v];
      for (int k = 0; k < 5; k++) w[k][b] = o[4 - k];
    end
    for (int i = 0; i < 5; i++) begin
      t = w[i];
      w[i] = t ^ rot_r(t, rot_a[i]) ^ rot_r(t, rot_b[i]);
    end
    for (int i = 0; i < 5; i++) r[i] = w[i];
    return r;
  endfunction

  function automatic int first_round(input logic mode);
`ifdef PERM_P6_MODE_EN
    return mode ? 6 : 0;
`else
    return 0;
`endif
  endfunction

  // Queue the full visible trace of one accepted permutation
  task automatic build_trace(input type_state in_st, input int first);
    type_state st;
    exp_t e;
    st = in_st;
    for (int j = first; j < 12; j++) begin
      e = '{busy: 1'b1, done: 1'b0, round: 4'(j), st: st};
      trace.push_back(e);
      st = ref_round(st, j);
    end
    e = '{busy: 1'b0, done: 1'b1, round: 4'd11, st: st};
    trace.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      trace.delete();
      cur = '0;
    end else if (!cur.busy && bus.start_i) begin
      trace.delete();
      build_trace(bus.state_i, first_round(bus.mode_i));
      cur = trace.pop_front();
    end else if (trace.size() > 0) begin
      cur = trace.pop_front();
    end else begin
      cur.busy = 1'b0;
      cur.done = 1'b0;
    end
    #1;
    check_val("busy",  320'(bus.busy_o),  320'(cur.busy));
    check_val("done",  320'(bus.done_o),  320'(cur.done));
    check_val("round", 320'(bus.round_o), 320'(cur.round));
    check_val("state", bus.state_o,       cur.st);
  endtask

  function automatic type_state rand_state();
    type_state s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  type_state vec;
  int        guard;

  initial begin
    vec = {64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
           64'h0001020304050607, 64'h08090A0B0C0D0E0F};
    cur = '0;
    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.state_i = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // p12 on the reference vector; inputs scrambled during RUN
    bus.state_i = vec; bus.mode_i = 1'b0; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0; bus.state_i = rand_state(); bus.mode_i = 1'b1;
    repeat (14) tick();

    // p6 request (p12 when the option is not built in)
    bus.state_i = vec; bus.mode_i = 1'b1; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0; bus.mode_i = 1'b0;
    repeat (14) tick();

    // start held high: back-to-back passes chaining the previous output
    bus.mode_i = 1'b1; bus.start_i = 1'b1;
    repeat (30) begin
      bus.state_i = cur.st;
      tick();
    end
    bus.start_i = 1'b0;
    repeat (14) tick();

    // reset in the middle of a p12 run, then a clean run
    bus.state_i = vec; bus.mode_i = 1'b0; bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    guard = 0;
    while (cur.round != 4'd5 && guard < 20) begin
      tick();
      guard++;
    end
    check_val("reach_round5", 320'(guard < 20), 320'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (14) tick();

    // random traffic including occasional resets
    repeat (400) begin
      bus.start_i = ($urandom_range(0, 3) == 0);
      bus.mode_i  = 1'($urandom);
      bus.state_i = rand_state();
      rst         = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    bus.start_i = 1'b0;
    repeat (15) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/permutation_sequencer.md
PERMUTATION_SEQUENCER -- requirements
Module: permutation_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list:
- clock_i: input, 1 bit; rising-edge clock.
- reset_i: input, 1 bit; synchronous, active-high reset.
- start_i: input, 1 bit; permutation request.
- mode_i: input, 1 bit; 0 = p12 (12 rounds), 1 = p6 (6 rounds).
- state_i: input, type_state (5 x 64 bits); state to be permuted.
- state_o: output, type_state; permutation state register.
- busy_o: output, 1 bit; permutation in progress.
- done_o: output, 1 bit; one-cycle completion pulse.
- round_o: output, 4 bits; current round-constant index.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-004 In IDLE or DONE, start_i=1 SHALL load state_i into the state register and go to RUN.
- The round index SHALL load 0 for p12 and 6 for p6.
REQ-005 Each RUN cycle SHALL update the state register once per edge as reg <= diffusion(substitution(constant_add(reg, round))), then increment the round index.
- The round constant SHALL be taken from the ascon_pack table: 0xF0, 0xE1, 0xD2, 0xC3, 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B for indices 0..11.
- The constant SHALL be XORed into the least-significant byte of word 2.
REQ-006 The round datapath SHALL reuse the team's existing constant-addition, substitution and diffusion layers, instantiated once and iterated (no unrolling).
REQ-007 The round that uses index 11 SHALL be the last round; its edge SHALL move the FSM to DONE.
REQ-008 Latency: with start_i sampled at edge k, the rounds SHALL occur at edges k+1..k+N (N=12 or 6).
- done_o SHALL be 1 for exactly the cycle after edge k+N.
REQ-009 busy_o SHALL be 1 exactly while the FSM is in RUN.
REQ-010 done_o SHALL be 1 exactly while the FSM is in DONE.
- DONE SHALL last one cycle, then return to IDLE unless start_i=1.
REQ-011 In RUN, start_i, mode_i and state_i SHALL be ignored; a request during RUN SHALL be neither queued nor aborting.
REQ-012 state_o SHALL show the register at all times and SHALL hold the final permuted value in DONE and IDLE until the next accepted start.
REQ-013 round_o SHALL show the index used in the current RUN cycle.
- round_o SHALL hold 11 in DONE and IDLE after a completed permutation.
- The round index SHALL never exceed 11 or wrap.
REQ-014 mode_i SHALL be sampled only when the request is accepted; changes during RUN SHALL have no effect.
REQ-015 start_i=1 in DONE SHALL start a new permutation directly, giving back-to-back operation with no idle cycle.

Reset
REQ-016 reset_i=1 at a rising edge SHALL set: FSM = IDLE, state register = 0, round index = 0, busy_o = 0, done_o = 0.
REQ-017 Reset SHALL take priority over start_i and over an operation in progress.
- Reset mid-RUN SHALL abort the permutation with no done_o pulse.
REQ-018 The first start_i accepted after reset is released SHALL behave identically to one accepted from power-up IDLE.

Configuration
REQ-019 Macro PERM_P6_MODE_EN, when defined, SHALL enable mode_i selection of p6 as in REQ-004.
REQ-020 Without PERM_P6_MODE_EN:
- mode_i SHALL be ignored.
- Every permutation SHALL run 12 rounds starting at index 0.
- The port list SHALL be unchanged.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then idle for 5 cycles -> state_o=0, busy_o=0, done_o=0, round_o=0 throughout.
- state_i = {80400C0600000000, 0001020304050607, 08090A0B0C0D0E0F, 0001020304050607, 08090A0B0C0D0E0F}, mode_i=0, start_i pulsed at edge k -> busy_o=1 during cycles k+1..k+12; round_o steps 0..11; done_o=1 only after edge k+12; state_o equals the golden software p12 result.
- Same state_i with mode_i=1 -> round_o steps 6..11; done_o only after edge k+6; state_o equals the golden p6 result.
- start_i held high continuously for 30 cycles with mode_i=1 -> done_o pulses every 7 cycles; each pass permutes the previous output.
- reset_i asserted at round index 5 of a p12 run -> next cycle shows state_o=0, busy_o=0, done_o never asserted; a following start completes normally.
- Build without PERM_P6_MODE_EN, mode_i=1 -> 12 rounds run starting at index 0, with output identical to p12.
